// File: rtl/pwrmgr_pkg.sv
// Shared types and constants for the pwrmgr wakeup/reset-request controller.
package pwrmgr_pkg;

    localparam int unsigned WakeIdxW = 4;

    // Sparse codes so that a single flipped bit never lands on another legal state.
    typedef enum logic [3:0] {
        Idle  = 4'b0011,
        Armed = 4'b0101,
        Req   = 4'b1001,
        Done  = 4'b1110
    } wake_ctrl_state_e;

endpackage

// File: rtl/pwrmgr_wake_filter.sv
// Per-source stability filter: asserted after FilterCycles consecutive high samples.
// Counter only exists when PWRMGR_WAKE_FILTER_EN is defined; otherwise a pass-through.
module pwrmgr_wake_filter #(
    parameter int unsigned FilterCycles = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic in_i,
    output logic asserted_o
);

`ifdef PWRMGR_WAKE_FILTER_EN
    localparam int unsigned CntW = $clog2(FilterCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!run_i || !in_i) begin
            cnt_q <= '0;
        end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign asserted_o = (cnt_q == CntMax);
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign asserted_o     = in_i & run_i;
`endif

endmodule

// File: rtl/pwrmgr_wake_ctrl.sv
// Arbitrates filtered wakeup/reset-request sources into a held request for the slow FSM.
// Optional stability filtering is enabled with PWRMGR_WAKE_FILTER_EN.
module pwrmgr_wake_ctrl
    import pwrmgr_pkg::*;
#(
    parameter int unsigned NumWkups     = 6,
    parameter int unsigned NumRstReqs   = 2,
    parameter int unsigned FilterCycles = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumWkups-1:0]   wakeups_i,
    input  logic [NumWkups-1:0]   wakeup_en_i,
    input  logic [NumRstReqs-1:0] rst_reqs_i,
    input  logic [NumRstReqs-1:0] rst_en_i,
    input  logic                  low_power_i,
    input  logic                  cause_toggle_i,
    input  logic                  clr_reason_i,
    output logic                  wakeup_o,
    output logic                  reset_req_o,
    output logic [NumWkups-1:0]   wake_reason_o,
    output logic [NumRstReqs-1:0] rst_reason_o,
    output logic [WakeIdxW-1:0]   wake_idx_o,
    output logic                  busy_o
);

    wake_ctrl_state_e        state_q;
    logic                    toggle_q;
    logic                    run;
    logic                    any_act;
    logic                    collect;
    logic [NumWkups-1:0]     wk_act;
    logic [NumRstReqs-1:0]   rst_act;

    function automatic logic [WakeIdxW-1:0] lowest_idx(input logic [NumWkups-1:0] v);
        lowest_idx = '0;
        for (int i = int'(NumWkups) - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = WakeIdxW'(i);
        end
    endfunction

    // Counters are held cleared while Idle so arming always starts a fresh count.
    assign run = (state_q != Idle);

    for (genvar i = 0; i < NumWkups; i++) begin : g_wk_filt
        pwrmgr_wake_filter #(.FilterCycles(FilterCycles)) u_filt (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .run_i      (run),
            .in_i       (wakeups_i[i] & wakeup_en_i[i]),
            .asserted_o (wk_act[i])
        );
    end

    for (genvar i = 0; i < NumRstReqs; i++) begin : g_rst_filt
        pwrmgr_wake_filter #(.FilterCycles(FilterCycles)) u_filt (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .run_i      (run),
            .in_i       (rst_reqs_i[i] & rst_en_i[i]),
            .asserted_o (rst_act[i])
        );
    end

    assign any_act = (|wk_act) | (|rst_act);
    // Armed only leaves with a capture when something is asserted, so both states can OR freely.
    assign collect = (state_q == Armed) || (state_q == Req);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wake_reason_o <= '0;
            rst_reason_o  <= '0;
        end else begin
            wake_reason_o <= (clr_reason_i ? '0 : wake_reason_o) | (collect ? wk_act  : '0);
            rst_reason_o  <= (clr_reason_i ? '0 : rst_reason_o)  | (collect ? rst_act : '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= Idle;
            toggle_q    <= 1'b0;
            wakeup_o    <= 1'b0;
            reset_req_o <= 1'b0;
            wake_idx_o  <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state_q)
                Idle: begin
                    if (low_power_i) begin
                        state_q <= Armed;
                        busy_o  <= 1'b1;
                    end
                end
                Armed: begin
                    if (any_act) begin
                        state_q     <= Req;
                        toggle_q    <= cause_toggle_i;
                        reset_req_o <= |rst_act;
                        wakeup_o    <= ~(|rst_act);
                        wake_idx_o  <= (|rst_act) ? '0 : lowest_idx(wk_act);
                    end else if (!low_power_i) begin
                        state_q <= Idle;
                        busy_o  <= 1'b0;
                    end
                end
                Req: begin
                    // The slow FSM acknowledges by flipping its cause toggle.
                    if (cause_toggle_i != toggle_q) begin
                        state_q     <= Done;
                        wakeup_o    <= 1'b0;
                        reset_req_o <= 1'b0;
                        wake_idx_o  <= '0;
                    end
                end
                Done: begin
                    if (!low_power_i) begin
                        state_q <= Idle;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= Idle;
                    wakeup_o    <= 1'b0;
                    reset_req_o <= 1'b0;
                    wake_idx_o  <= '0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwrmgr_wake_ctrl.sv
// Scoreboard bench for pwrmgr_wake_ctrl: episode waveforms are predicted from the source rules,
// expected requests are queued, and a monitor compares each request the DUT raises.
`timescale 1ns/1ps
module tb_pwrmgr_wake_ctrl;

    localparam int NW   = 6;
    localparam int NR   = 2;
    localparam int FC   = 4;
    localparam int MAXC = 64;
`ifdef PWRMGR_WAKE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [NW-1:0] wakeups_i, wakeup_en_i;
    logic [NR-1:0] rst_reqs_i, rst_en_i;
    logic          low_power_i, cause_toggle_i, clr_reason_i;
    logic          wakeup_o, reset_req_o, busy_o;
    logic [NW-1:0] wake_reason_o;
    logic [NR-1:0] rst_reason_o;
    logic [3:0]    wake_idx_o;

    always #5 clk = ~clk;

    pwrmgr_wake_ctrl #(.NumWkups(NW), .NumRstReqs(NR), .FilterCycles(FC)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .wakeups_i      (wakeups_i),
        .wakeup_en_i    (wakeup_en_i),
        .rst_reqs_i     (rst_reqs_i),
        .rst_en_i       (rst_en_i),
        .low_power_i    (low_power_i),
        .cause_toggle_i (cause_toggle_i),
        .clr_reason_i   (clr_reason_i),
        .wakeup_o       (wakeup_o),
        .reset_req_o    (reset_req_o),
        .wake_reason_o  (wake_reason_o),
        .rst_reason_o   (rst_reason_o),
        .wake_idx_o     (wake_idx_o),
        .busy_o         (busy_o)
    );

    typedef struct {
        logic          wk;
        logic          rs;
        logic [3:0]    idx;
        logic [NW-1:0] wr;
        logic [NR-1:0] rr;
        int            dur;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;
    bit   mon_off = 1'b0;

    // Episode waveform: one entry per clock edge.
    logic [NW-1:0] w_wk [MAXC];
    logic [NR-1:0] w_rs [MAXC];
    logic          w_lp [MAXC];
    logic          w_clr[MAXC];
    logic [NW-1:0] w_wen;
    logic [NR-1:0] w_ren;
    int            w_n;
    logic [NW-1:0] m_wr = '0;
    logic [NR-1:0] m_rr = '0;
    logic          tgl = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic bit hi(input int s, input int k);
        if (s < NW) return w_wk[k][s] & w_wen[s];
        return w_rs[k][s-NW] & w_ren[s-NW];
    endfunction

    // Sources asserted at edge e, given the edge at which the controller armed.
    function automatic logic [NW+NR-1:0] act_at(input int e, input int arm);
        logic [NW+NR-1:0] v;
        bit ok;
        v = '0;
        for (int s = 0; s < NW + NR; s++) begin
            if (FILT) begin
                ok = (e - FC >= arm + 1);
                for (int k = e - FC; k < e; k++) if (k >= 0 && !hi(s, k)) ok = 1'b0;
            end else begin
                ok = (e > arm) && hi(s, e);
            end
            v[s] = ok;
        end
        return v;
    endfunction

    task automatic put(input logic lp, input logic [NW-1:0] wk, input logic [NR-1:0] rs,
                       input logic clr, input int reps);
        for (int k = 0; k < reps; k++) begin
            w_lp[w_n] = lp; w_wk[w_n] = wk; w_rs[w_n] = rs; w_clr[w_n] = clr;
            w_n++;
        end
    endtask

    task automatic add_tail();
        put(1'b0, '0, '0, 1'b0, FC + 4);
    endtask

    task automatic run_episode();
        int arm = -1;
        int ce  = -1;
        int a;
        logic [NW+NR-1:0] v, capv;
        exp_t e;
        a = w_n - 1;
        capv = '0;
        e = '{wk: 1'b0, rs: 1'b0, idx: 4'd0, wr: '0, rr: '0, dur: 0};
        for (int c = 0; c < w_n; c++) if (w_lp[c]) begin arm = c; break; end
        if (arm >= 0) begin
            for (int c = arm + 1; c < w_n; c++) begin
                v = act_at(c, arm);
                if (|v) begin ce = c; capv = v; break; end
                if (!w_lp[c]) break;
            end
        end
        for (int c = 0; c < w_n; c++) begin
            if (w_clr[c]) begin m_wr = '0; m_rr = '0; end
            if (ce >= 0 && c >= ce && c <= a) begin
                v = (c == ce) ? capv : act_at(c, arm);
                m_wr |= v[NW-1:0];
                m_rr |= v[NW+NR-1:NW];
            end
            if (c == ce) begin e.wr = m_wr; e.rr = m_rr; end
        end
        if (ce >= 0) begin
            e.rs  = |capv[NW+NR-1:NW];
            e.wk  = ~e.rs;
            for (int i = NW - 1; i >= 0; i--) if (capv[i]) e.idx = 4'(i);
            e.dur = a - ce;
            sb.push_back(e);
        end
        wakeup_en_i = w_wen;
        rst_en_i    = w_ren;
        for (int c = 0; c < w_n; c++) begin
            low_power_i  = w_lp[c];
            wakeups_i    = w_wk[c];
            rst_reqs_i   = w_rs[c];
            clr_reason_i = w_clr[c];
            if (ce >= 0 && c == a) tgl = ~tgl;
            cause_toggle_i = tgl;
            @(posedge clk); #1;
        end
        low_power_i = 1'b0; wakeups_i = '0; rst_reqs_i = '0; clr_reason_i = 1'b0;
        for (int k = 0; k < 8 && busy_o; k++) begin @(posedge clk); #1; end
        chk("busy_after_episode", 32'(busy_o), 32'(0));
        chk("wake_reason_after_episode", 32'(wake_reason_o), 32'(m_wr));
        chk("rst_reason_after_episode", 32'(rst_reason_o), 32'(m_rr));
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        if (busy_o || sb.size() != 0) begin
            rst_ni = 1'b0; #1; rst_ni = 1'b1;
            sb.delete(); m_wr = '0; m_rr = '0;
            @(posedge clk); #1;
        end
    endtask

    task automatic gen_random();
        int L, drop;
        logic [NW-1:0] lw;
        logic [NR-1:0] lr;
        L     = $urandom_range(3, 16);
        drop  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, L) : -1;
        w_wen = NW'($urandom);
        w_ren = NR'($urandom);
        lw    = NW'($urandom);
        lr    = '0;
        w_n   = 0;
        for (int c = 0; c < L; c++) begin
            if (c > 0) begin
                for (int s = 0; s < NW; s++) if ($urandom_range(0, 5) == 0) lw[s] = ~lw[s];
                for (int s = 0; s < NR; s++) if ($urandom_range(0, 11) == 0) lr[s] = ~lr[s];
            end
            put((drop < 0 || c < drop), lw, lr, ($urandom_range(0, 7) == 0), 1);
        end
        add_tail();
    endtask

    initial begin : monitor
        logic prev, have, req;
        int   dur;
        exp_t cur;
        logic [5:0] snap;
        prev = 1'b0; have = 1'b0; dur = 0; snap = '0;
        cur = '{wk: 1'b0, rs: 1'b0, idx: 4'd0, wr: '0, rr: '0, dur: 0};
        forever begin
            @(negedge clk);
            req = wakeup_o | reset_req_o;
            if (!rst_ni || mon_off) begin
                prev = 1'b0; have = 1'b0;
            end else begin
                if (req && !prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_request", 32'(req), 32'(0));
                    end else begin
                        cur = sb.pop_front(); have = 1'b1; dur = 0;
                        chk("req_wakeup", 32'(wakeup_o), 32'(cur.wk));
                        chk("req_reset", 32'(reset_req_o), 32'(cur.rs));
                        if (cur.wk) chk("req_wake_idx", 32'(wake_idx_o), 32'(cur.idx));
                        chk("req_wake_reason", 32'(wake_reason_o), 32'(cur.wr));
                        chk("req_rst_reason", 32'(rst_reason_o), 32'(cur.rr));
                        snap = {wakeup_o, reset_req_o, wake_idx_o};
                    end
                end
                if (req && have) begin
                    dur++;
                    chk("req_stable", 32'({wakeup_o, reset_req_o, wake_idx_o}), 32'(snap));
                end
                if (!req && prev && have) begin
                    chk("req_duration", 32'(dur), 32'(cur.dur));
                    have = 1'b0;
                end
                prev = req;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", nchk);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cap;
        rst_ni = 1'b0;
        wakeups_i = '0; wakeup_en_i = '0; rst_reqs_i = '0; rst_en_i = '0;
        low_power_i = 1'b0; cause_toggle_i = 1'b0; clr_reason_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({wakeup_o, reset_req_o, busy_o, wake_idx_o, wake_reason_o, rst_reason_o}), 32'(0));
        rst_ni = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_busy", 32'(busy_o), 32'(0));

        // Basic wakeup on source 3.
        w_wen = '1; w_ren = '1; w_n = 0;
        put(1'b1, '0, '0, 1'b0, 1); put(1'b1, 6'b001000, '0, 1'b0, 10); add_tail();
        run_episode();
        chk("basic_reason_const", 32'(wake_reason_o), 32'(6'b001000));
        // Glitch rejection.
        w_n = 0;
        put(1'b1, '0, '0, 1'b1, 1); put(1'b1, 6'b000001, '0, 1'b0, 3); put(1'b1, '0, '0, 1'b0, 1);
        put(1'b1, 6'b000001, '0, 1'b0, 3); put(1'b1, '0, '0, 1'b0, 2); add_tail();
        run_episode();
        // Reset has priority over wakeup.
        w_n = 0;
        put(1'b1, '0, '0, 1'b1, 1); put(1'b1, 6'b000010, 2'b01, 1'b0, 8); add_tail();
        run_episode();
        // Disabled source.
        w_wen = 6'b111011; w_n = 0;
        put(1'b1, '0, '0, 1'b1, 1); put(1'b1, 6'b000100, '0, 1'b0, 8); add_tail();
        run_episode();
        // Enabled source without low power.
        w_wen = '1; w_n = 0;
        put(1'b0, 6'b000100, '0, 1'b1, 8); add_tail();
        run_episode();
        // Abort in Armed after two high samples.
        w_n = 0;
        put(1'b1, '0, '0, 1'b1, 1); put(1'b1, 6'b000001, '0, 1'b0, 2); put(1'b0, 6'b000001, '0, 1'b0, 3);
        add_tail();
        run_episode();
        // Clear coinciding with the capture of source 5.
        cap = FILT ? FC + 1 : 1;
        w_n = 0;
        put(1'b1, '0, '0, 1'b0, 1); put(1'b1, 6'b100000, '0, 1'b0, 8); add_tail();
        w_clr[cap] = 1'b1;
        run_episode();
        chk("clr_vs_capture_bit5", 32'(wake_reason_o[5]), 32'(1));

        for (int ep = 0; ep < 40; ep++) begin
            gen_random();
            run_episode();
        end

        // Asynchronous reset while a request is held.
        mon_off = 1'b1;
        wakeup_en_i = '1; wakeups_i = 6'b100000; low_power_i = 1'b1;
        for (int k = 0; k < 20 && !wakeup_o; k++) begin @(posedge clk); #1; end
        chk("async_pre_wakeup", 32'(wakeup_o), 32'(1));
        #2 rst_ni = 1'b0;
        #1;
        chk("async_wakeup_cleared", 32'(wakeup_o), 32'(0));
        chk("async_reasons_cleared", 32'({wake_reason_o, rst_reason_o}), 32'(0));
        chk("async_busy_cleared", 32'(busy_o), 32'(0));
        wakeups_i = '0; low_power_i = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        chk("async_post_release", 32'({wakeup_o, reset_req_o, busy_o}), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
